plate_check_arbiter: RTL

- Shares one plate validator and the invalid-plate history log between two plate-entry requesters (gate 0 = entry, gate 1 = exit).
- Arbitrates round-robin and sequences each check: launch validator, wait for result, answer requester, log invalid plate.
- Sits between the gate capture logic and the validator / last-two-invalid-plates store.
- Keeps a saturating invalid-plate counter and a sticky timeout error flag.

---
 rtl/plate_check_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/plate_check_arbiter.sv
// Round-robin arbiter that shares one plate validator and the invalid-plate log
// between gate 0 (entry) and gate 1 (exit), sequencing each check as IDLE -> START -> WAIT -> RESP.
//
// Handshake: a gate raises reqN and holds plateN stable until it sees a one-cycle ackN pulse;
// okN is meaningful only while ackN is high, and the gate drops reqN at the edge where it samples ackN.
module plate_check_arbiter #(
    parameter int PLATE_W = 24,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic [PLATE_W-1:0] plate0,
    output logic               ack0,
    output logic               ok0,
    input  logic               req1,
    input  logic [PLATE_W-1:0] plate1,
    output logic               ack1,
    output logic               ok1,
    output logic               val_start,
    output logic [PLATE_W-1:0] val_plate,
    input  logic               val_done,
    input  logic               val_ok,
    output logic               log_wr,
    output logic [PLATE_W-1:0] log_plate,
    output logic [CNT_W-1:0]   n_invalid,
    output logic               tmo_err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               last_q, last_d;
    logic [PLATE_W-1:0] plate_q, plate_d;
    logic               verdict_q, verdict_d;
    logic               tmo_ev_q, tmo_ev_d;
    logic               tmo_err_q, tmo_err_d;
    logic [CNT_W-1:0]   n_inv_q, n_inv_d;
    logic               ack0_q, ack0_d;
    logic               ok0_q, ok0_d;
    logic               ack1_q, ack1_d;
    logic               ok1_q, ok1_d;
    logic               start_q, start_d;
    logic               log_q, log_d;
    logic               gsel;
    logic               resp_d;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        last_d    = last_q;
        plate_d   = plate_q;
        verdict_d = verdict_q;
        tmo_ev_d  = tmo_ev_q;
        tmo_err_d = tmo_err_q;
        n_inv_d   = n_inv_q;
        gsel      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Under contention the gate that did not win last time gets the validator.
                    gsel    = (req0 && req1) ? ~last_q : req1;
                    last_d  = gsel;
                    plate_d = gsel ? plate1 : plate0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (val_done) begin
                    verdict_d = val_ok;
                    tmo_ev_d  = 1'b0;
                    state_d   = S_RESP;
                end else if (tcnt_q == TMO_LAST) begin
                    verdict_d = 1'b0;
                    tmo_ev_d  = 1'b1;
                    tmo_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the decode of the state being entered.
        resp_d  = (state_d == S_RESP);
        start_d = (state_d == S_START);
        ack0_d  = resp_d && !last_d;
        ack1_d  = resp_d && last_d;
        ok0_d   = ack0_d && verdict_d;
        ok1_d   = ack1_d && verdict_d;
        log_d   = resp_d && !verdict_d && !tmo_ev_d;
        if (log_d && (n_inv_q != {CNT_W{1'b1}})) begin
            n_inv_d = n_inv_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            last_q    <= 1'b1;
            plate_q   <= '0;
            verdict_q <= 1'b0;
            tmo_ev_q  <= 1'b0;
            tmo_err_q <= 1'b0;
            n_inv_q   <= '0;
            ack0_q    <= 1'b0;
            ok0_q     <= 1'b0;
            ack1_q    <= 1'b0;
            ok1_q     <= 1'b0;
            start_q   <= 1'b0;
            log_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            last_q    <= last_d;
            plate_q   <= plate_d;
            verdict_q <= verdict_d;
            tmo_ev_q  <= tmo_ev_d;
            tmo_err_q <= tmo_err_d;
            n_inv_q   <= n_inv_d;
            ack0_q    <= ack0_d;
            ok0_q     <= ok0_d;
            ack1_q    <= ack1_d;
            ok1_q     <= ok1_d;
            start_q   <= start_d;
            log_q     <= log_d;
        end
    end

    assign ack0      = ack0_q;
    assign ok0       = ok0_q;
    assign ack1      = ack1_q;
    assign ok1       = ok1_q;
    assign val_start = start_q;
    assign val_plate = plate_q;
    assign log_wr    = log_q;
    assign log_plate = plate_q;
    assign n_invalid = n_inv_q;
    assign tmo_err   = tmo_err_q;
endmodule
